vpu_dispatch: RTL and testbench

- Instruction queue and issue sequencer directly upstream of the VPU.
- Accepts packed 64-bit VPU instruction words from the host/control path over a valid/ready handshake and buffers them in a FIFO.
- Decodes each word into opcode and address fields, then issues it with a one-cycle start pulse.
- Holds the fields stable until the VPU returns done, then issues the next word. A word never overlaps the previous one.

---
 rtl/vpu_dispatch.sv | 147 ++++++++++++++
 tb/tb_vpu_dispatch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_dispatch.sv
// ============================================================================
// vpu_dispatch : instruction FIFO and issue sequencer feeding the VPU.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module vpu_dispatch #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 13,
    parameter int OP_W   = 10,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [63:0]                cmd_data,
    input  logic                       enable,
    input  logic                       flush,
    output logic [OP_W-1:0]            opcode,
    output logic [ADDR_W-1:0]          inst_addr_a,
    output logic [ADDR_W-1:0]          inst_addr_b,
    output logic [ADDR_W-1:0]          inst_addr_c,
    output logic [ADDR_W-1:0]          inst_addr_const,
    output logic                       start,
    input  logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           retired_count,
    output logic                       err_spurious
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int OP_LSB = 0;
    localparam int A_LSB  = 10;
    localparam int B_LSB  = 23;
    localparam int C_LSB  = 36;
    localparam int K_LSB  = 49;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [61:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CW-1:0]     count;
    logic [61:0]       head;
    logic              push;
    logic              pop;
    logic              unused_rsvd;

    // Reserved instruction bits are dropped at the FIFO input.
    assign unused_rsvd = &{1'b0, cmd_data[63:62]};

    assign cmd_ready  = (count < CW'(DEPTH));
    assign fifo_count = count;
    assign head       = mem[rd_ptr];
    assign push       = cmd_valid && cmd_ready && !flush;
    assign pop        = (count != '0) && enable && !flush &&
                        ((state == S_IDLE) || done);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data[61:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            start           <= 1'b0;
            busy            <= 1'b0;
            opcode          <= '0;
            inst_addr_a     <= '0;
            inst_addr_b     <= '0;
            inst_addr_c     <= '0;
            inst_addr_const <= '0;
            retired_count   <= '0;
            err_spurious    <= 1'b0;
        end else begin
            start <= pop;
            if (pop) begin
                opcode          <= head[OP_LSB +: OP_W];
                inst_addr_a     <= head[A_LSB +: ADDR_W];
                inst_addr_b     <= head[B_LSB +: ADDR_W];
                inst_addr_c     <= head[C_LSB +: ADDR_W];
                inst_addr_const <= head[K_LSB +: ADDR_W];
            end
            case (state)
                S_IDLE: begin
                    if (done) begin
                        err_spurious <= 1'b1;
                    end
                    if (pop) begin
                        busy  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        retired_count <= retired_count + 1'b1;
                        // Back-to-back issue keeps us in WAIT with busy held.
                        if (!pop) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vpu_dispatch.sv
// ============================================================================
// tb_vpu_dispatch : directed + randomized bench with a queue-based reference.
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vpu_dispatch;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 13;
    localparam int OP_W   = 10;
    localparam int CNT_W  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [63:0]       cmd_data;
    logic              enable;
    logic              flush;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] inst_addr_a;
    logic [ADDR_W-1:0] inst_addr_b;
    logic [ADDR_W-1:0] inst_addr_c;
    logic [ADDR_W-1:0] inst_addr_const;
    logic              start;
    logic              done;
    logic              busy;
    logic [CW-1:0]     fifo_count;
    logic [CNT_W-1:0]  retired_count;
    logic              err_spurious;

    vpu_dispatch #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .OP_W  (OP_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .enable         (enable),
        .flush          (flush),
        .opcode         (opcode),
        .inst_addr_a    (inst_addr_a),
        .inst_addr_b    (inst_addr_b),
        .inst_addr_c    (inst_addr_c),
        .inst_addr_const(inst_addr_const),
        .start          (start),
        .done           (done),
        .busy           (busy),
        .fifo_count     (fifo_count),
        .retired_count  (retired_count),
        .err_spurious   (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: queued words, last issued word, in-flight flag, VPU countdown.
    logic [63:0] q [$];
    logic [63:0] m_last;
    bit          m_busy;
    bit          m_start;
    bit          m_err;
    int          m_ret;
    int          cd;
    int          lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last  = '0;
        m_busy  = 1'b0;
        m_start = 1'b0;
        m_err   = 1'b0;
        m_ret   = 0;
        cd      = 0;
    endtask

    task automatic check_all();
        chk("start",      64'(start),           64'(m_start));
        chk("busy",       64'(busy),            64'(m_busy));
        chk("fifo_count", 64'(fifo_count),      64'(q.size()));
        chk("cmd_ready",  64'(cmd_ready),       64'(q.size() < DEPTH));
        chk("retired",    64'(retired_count),   64'(m_ret % (1 << CNT_W)));
        chk("err",        64'(err_spurious),    64'(m_err));
        chk("opcode",     64'(opcode),          64'(m_last[9:0]));
        chk("addr_a",     64'(inst_addr_a),     64'(m_last[22:10]));
        chk("addr_b",     64'(inst_addr_b),     64'(m_last[35:23]));
        chk("addr_c",     64'(inst_addr_c),     64'(m_last[48:36]));
        chk("addr_const", 64'(inst_addr_const), 64'(m_last[61:49]));
    endtask

    // One clock cycle: drive inputs, advance the reference, check after the edge.
    task automatic step(input bit v, input logic [63:0] d, input bit en,
                        input bit fl, input bit spur);
        bit iss;
        bit dn;
        bit acc;
        dn        = spur || (cd == 1);
        cmd_valid = v;
        cmd_data  = d;
        enable    = en;
        flush     = fl;
        done      = dn;
        iss = (q.size() > 0) && en && !fl && (!m_busy || dn);
        acc = v && (q.size() < DEPTH) && !fl;
        if (m_busy && dn) m_ret++;
        if (!m_busy && dn) m_err = 1'b1;
        if (fl) begin
            q.delete();
        end else begin
            if (iss) m_last = q.pop_front();
            if (acc) q.push_back(d);
        end
        m_start = iss;
        m_busy  = iss || (m_busy && !dn);
        @(posedge clk);
        #1;
        check_all();
        if (m_start) cd = lat + 1;
        else if (cd > 0) cd--;
    endtask

    function automatic logic [63:0] word(input int op, input int a, input int b,
                                         input int c, input int k);
        return {2'b00, 13'(k), 13'(c), 13'(b), 13'(a), 10'(op)};
    endfunction

    function automatic logic [63:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        enable    = 1'b0;
        flush     = 1'b0;
        done      = 1'b0;
        lat       = 7;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Spurious done with nothing issued.
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 0);
        chk("spur_err_sticky", 64'(err_spurious), 64'd1);
        chk("spur_retired",    64'(retired_count), 64'd0);

        // Single instruction: op=3 a=5 b=6 c=7 const=0.
        step(1, word(3, 5, 6, 7, 0), 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, '0, 1, 0, 0);
            if (i == 0) begin
                chk("t1_start",  64'(start),  64'd1);
                chk("t1_opcode", 64'(opcode), 64'd3);
                chk("t1_addr_c", 64'(inst_addr_c), 64'd7);
            end
        end
        chk("t1_retired", 64'(retired_count), 64'd1);
        chk("t1_busy",    64'(busy),          64'd0);

        // Back-to-back: three words.
        step(1, word(11, 1, 2, 3, 4), 1, 0, 0);
        step(1, word(12, 5, 6, 7, 8), 1, 0, 0);
        step(1, word(13, 9, 10, 11, 12), 1, 0, 0);
        repeat (30) step(0, '0, 1, 0, 0);
        chk("t2_retired", 64'(retired_count), 64'd4);
        chk("t2_empty",   64'(fifo_count),    64'd0);

        // Full FIFO with issue held off.
        for (int i = 0; i < 9; i++) step(1, word(100 + i, i, i + 1, i + 2, i + 3), 0, 0, 0);
        chk("t3_ready_full", 64'(cmd_ready),  64'd0);
        chk("t3_count_full", 64'(fifo_count), 64'd8);
        repeat (8 * 9 + 4) step(0, '0, 1, 0, 0);
        chk("t3_retired", 64'(retired_count), 64'(12 % 16));

        // Flush while the first of four is in flight.
        for (int i = 0; i < 4; i++) step(1, word(200 + i, 20, 21, 22, 23), 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 1, 0);
        chk("t4_flush_count", 64'(fifo_count), 64'd0);
        repeat (12) step(0, '0, 1, 0, 0);
        chk("t4_retired", 64'(retired_count), 64'(13 % 16));

        // Reset while an instruction is in flight.
        step(1, word(300, 30, 31, 32, 33), 1, 0, 0);
        repeat (3) step(0, '0, 1, 0, 0);
        chk("t6_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, word(301, 40, 41, 42, 43), 1, 0, 0);
        repeat (10) step(0, '0, 1, 0, 0);
        chk("t6_retired_after", 64'(retired_count), 64'd1);

        // Randomized traffic; CNT_W is small so retired_count wraps here.
        for (int i = 0; i < 600; i++) begin
            if (cd == 0) lat = $urandom_range(1, 5);
            step($urandom_range(0, 1) == 1, rnd_word(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, !m_busy && ($urandom_range(0, 63) == 0));
        end
        repeat (20) step(0, '0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
